sysid_probe_master: RTL and testbench

SYSID_PROBE_MASTER -- requirements
Module: sysid_probe_master

---
 rtl/sysid_probe_pkg.sv | 31 +++
 rtl/sysid_probe_lat_pipe.sv | 31 +++
 rtl/sysid_probe_master.sv | 175 +++++++++++++++++
 tb/tb_sysid_probe_master.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sysid_probe_pkg.sv
// Shared types and constants for the sysid probe master.
// Word map of the sysid slave, stall counter width and the FSM state encoding.
package sysid_probe_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STALL_W = 16;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    LAT_ID,
    RD_TS,
    LAT_TS,
    DONE
  } state_t;

  // Sticky result flags reported for one probe.
  typedef struct packed {
    logic id_ok;
    logic ts_ok;
    logic timeout;
  } probe_status_t;

  function automatic logic is_busy(input state_t s);
    return !((s == IDLE) || (s == DONE));
  endfunction

endpackage

// File: rtl/sysid_probe_lat_pipe.sv
// Delays the read-accept pulse by READ_LATENCY cycles to form the data capture strobe.
// A latency of zero turns the strobe into the accept pulse itself.
module sysid_probe_lat_pipe #(
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic accept,
  output logic capture_c
);

  if (READ_LATENCY == 0) begin : g_direct
    logic unused_clk_rst;
    assign unused_clk_rst = clock ^ reset_n;
    assign capture_c      = accept;
  end else begin : g_pipe
    logic [READ_LATENCY-1:0] pipe;

    // Reset empties the pipe so no in-flight read can be captured after release.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        pipe <= '0;
      end else begin
        pipe <= (pipe << 1) | READ_LATENCY'(accept);
      end
    end

    assign capture_c = pipe[READ_LATENCY-1];
  end

endmodule

// File: rtl/sysid_probe_master.sv
// Avalon-MM master that reads the sysid slave's ID and timestamp words and
// compares them with the expected build values, reporting pass/fail/timeout.
module sysid_probe_master
  import sysid_probe_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1457990783,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic              busy,
  output logic              done,
  output logic              id_ok,
  output logic              ts_ok,
  output logic              timeout,
  output logic [DATA_W-1:0] id_value,
  output logic [DATA_W-1:0] ts_value
);

  state_t               state, state_d;
  logic                 armed, armed_d;
  logic [STALL_W-1:0]   stall_cnt, stall_cnt_d;
  logic [STALL_W-1:0]   stall_inc_c;
  probe_status_t        status, status_d;
  logic [DATA_W-1:0]    id_value_d, ts_value_d;
  logic                 avm_read_d, avm_address_d, busy_d, done_d;
  logic                 accept_c, capture_c, stall_limit_c;

  assign accept_c      = ((state == RD_ID) || (state == RD_TS)) && !avm_waitrequest;
  assign stall_inc_c   = stall_cnt + STALL_W'(1);
  assign stall_limit_c = avm_waitrequest && (stall_inc_c == STALL_W'(TIMEOUT_CYCLES));

  sysid_probe_lat_pipe #(
    .READ_LATENCY (READ_LATENCY)
  ) u_lat_pipe (
    .clock     (clock),
    .reset_n   (reset_n),
    .accept    (accept_c),
    .capture_c (capture_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    armed_d     = armed;
    stall_cnt_d = stall_cnt;
    status_d    = status;
    id_value_d  = id_value;
    ts_value_d  = ts_value;

    case (state)
      IDLE: begin
        if (start || armed) begin
          state_d     = RD_ID;
          armed_d     = 1'b0;
          stall_cnt_d = '0;
        end
      end

      RD_ID: begin
        if (!avm_waitrequest) begin
          if (capture_c) begin
            id_value_d     = avm_readdata;
            status_d.id_ok = (avm_readdata == EXPECTED_ID);
            stall_cnt_d    = '0;
            state_d        = RD_TS;
          end else begin
            state_d = LAT_ID;
          end
        end else begin
          stall_cnt_d = stall_inc_c;
          if (stall_limit_c) begin
            status_d.timeout = 1'b1;
            status_d.id_ok   = 1'b0;
            status_d.ts_ok   = 1'b0;
            state_d          = DONE;
          end
        end
      end

      LAT_ID: begin
        if (capture_c) begin
          id_value_d     = avm_readdata;
          status_d.id_ok = (avm_readdata == EXPECTED_ID);
          stall_cnt_d    = '0;
          state_d        = RD_TS;
        end
      end

      RD_TS: begin
        if (!avm_waitrequest) begin
          if (capture_c) begin
            ts_value_d     = avm_readdata;
            status_d.ts_ok = (avm_readdata == EXPECTED_TS);
            state_d        = DONE;
          end else begin
            state_d = LAT_TS;
          end
        end else begin
          stall_cnt_d = stall_inc_c;
          if (stall_limit_c) begin
            status_d.timeout = 1'b1;
            status_d.ts_ok   = 1'b0;
            state_d          = DONE;
          end
        end
      end

      LAT_TS: begin
        if (capture_c) begin
          ts_value_d     = avm_readdata;
          status_d.ts_ok = (avm_readdata == EXPECTED_TS);
          state_d        = DONE;
        end
      end

      DONE: begin
        if (start) begin
          status_d    = '0;
          stall_cnt_d = '0;
          state_d     = RD_ID;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Bus and status outputs are registered copies of the next-state decode.
    avm_read_d    = (state_d == RD_ID) || (state_d == RD_TS);
    avm_address_d = ((state_d == RD_TS) || (state_d == LAT_TS)) ? ADDR_TS : ADDR_ID;
    busy_d        = is_busy(state_d);
    done_d        = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      armed       <= AUTO_START;
      stall_cnt   <= '0;
      status      <= '0;
      id_value    <= '0;
      ts_value    <= '0;
      avm_read    <= 1'b0;
      avm_address <= ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      armed       <= armed_d;
      stall_cnt   <= stall_cnt_d;
      status      <= status_d;
      id_value    <= id_value_d;
      ts_value    <= ts_value_d;
      avm_read    <= avm_read_d;
      avm_address <= avm_address_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  assign id_ok   = status.id_ok;
  assign ts_ok   = status.ts_ok;
  assign timeout = status.timeout;

endmodule

// File: tb/tb_sysid_probe_master.sv
// Directed bench for sysid_probe_master: a zero-latency no-wait instance (u0)
// and a latency-2 instance with a programmable stalling slave (u1).
module tb_sysid_probe_master;

  localparam logic [31:0] TS_DEF = 32'd1457990783;
  localparam logic [31:0] ID1    = 32'h1234_5678;
  localparam logic [31:0] TS1    = 32'h0BAD_F00D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // u0 signals
  logic        rst0_n, start0, addr0, read0, busy0, done0, idok0, tsok0, tmo0;
  logic        wait0;
  logic [31:0] rdata0, idv0, tsv0, sid0, sts0;

  // u1 signals
  logic        rst1_n, start1, addr1, read1, busy1, done1, idok1, tsok1, tmo1;
  logic        wait1;
  logic [31:0] rdata1, idv1, tsv1;

  assign wait0  = 1'b0;
  assign rdata0 = addr0 ? sts0 : sid0;

  // Slave for u1: stalls wait_n1 cycles per read, returns data exactly 2 cycles after acceptance.
  int   stall_ctr1 = 0;
  int   wait_n1    = 0;
  logic v1_a = 1'b0, v1_b = 1'b0, a1_a = 1'b0, a1_b = 1'b0;

  assign wait1  = read1 && (stall_ctr1 < wait_n1);
  assign rdata1 = v1_b ? (a1_b ? TS1 : ID1) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (read1 && wait1) stall_ctr1 <= stall_ctr1 + 1;
    else                stall_ctr1 <= 0;
    v1_a <= read1 && !wait1;
    a1_a <= addr1;
    v1_b <= v1_a;
    a1_b <= a1_a;
  end

  sysid_probe_master u0 (
    .clock           (clk),
    .reset_n         (rst0_n),
    .start           (start0),
    .avm_address     (addr0),
    .avm_read        (read0),
    .avm_waitrequest (wait0),
    .avm_readdata    (rdata0),
    .busy            (busy0),
    .done            (done0),
    .id_ok           (idok0),
    .ts_ok           (tsok0),
    .timeout         (tmo0),
    .id_value        (idv0),
    .ts_value        (tsv0)
  );

  sysid_probe_master #(
    .EXPECTED_ID    (ID1),
    .EXPECTED_TS    (TS1),
    .READ_LATENCY   (2),
    .TIMEOUT_CYCLES (8),
    .AUTO_START     (1'b1)
  ) u1 (
    .clock           (clk),
    .reset_n         (rst1_n),
    .start           (start1),
    .avm_address     (addr1),
    .avm_read        (read1),
    .avm_waitrequest (wait1),
    .avm_readdata    (rdata1),
    .busy            (busy1),
    .done            (done1),
    .id_ok           (idok1),
    .ts_ok           (tsok1),
    .timeout         (tmo1),
    .id_value        (idv1),
    .ts_value        (tsv1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int which, input string tag, input int budget);
    int n = 0;
    while (((which == 0) ? done0 : done1) !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'((which == 0) ? done0 : done1), 32'd1);
  endtask

  initial begin
    logic held_ad;
    logic was_accept;
    int   stalls;
    int   rd_cycles;
    logic found;

    rst0_n = 1'b0; rst1_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    sid0 = 32'd0; sts0 = TS_DEF; wait_n1 = 0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst0_flags", 32'({busy0, done0, read0, addr0, idok0, tsok0, tmo0}), 32'd0);
    chk("rst0_vals",  idv0 | tsv0, 32'd0);
    chk("rst1_flags", 32'({busy1, done1, read1, addr1, idok1, tsok1, tmo1}), 32'd0);

    // Auto-start probe on u0: RD_ID, RD_TS, DONE on consecutive edges
    rst0_n = 1'b1; rst1_n = 1'b1;
    @(negedge clk);
    chk("auto_rd_id",   32'({busy0, read0, addr0}), 32'b110);
    @(negedge clk);
    chk("auto_rd_ts",   32'({busy0, read0, addr0}), 32'b111);
    chk("auto_id_ok",   32'(idok0), 32'd1);
    @(negedge clk);
    chk("done_2cyc",    32'({done0, busy0, read0}), 32'b100);
    chk("auto_status",  32'({idok0, tsok0, tmo0}), 32'b110);
    chk("auto_ts_val",  tsv0, TS_DEF);
    repeat (3) @(negedge clk);
    chk("one_launch",   32'({done0, busy0}), 32'b10);

    // Auto-start probe on u1 (latency 2, no stall)
    wait_done(1, "u1_auto_done", 20);
    chk("u1_auto_status", 32'({idok1, tsok1, tmo1}), 32'b110);
    chk("u1_auto_id",     idv1, ID1);
    chk("u1_auto_ts",     tsv1, TS1);

    // Wrong timestamp; start pulse while busy is ignored
    sts0 = 32'h56E0_0000;
    start0 = 1'b1; @(negedge clk); start0 = 1'b0;
    chk("reprobe_clear", 32'({done0, busy0, idok0, tsok0, tmo0}), 32'b01000);
    start0 = 1'b1; @(negedge clk); start0 = 1'b0;
    @(negedge clk);
    chk("bad_ts_done",   32'(done0), 32'd1);
    chk("bad_ts_status", 32'({idok0, tsok0, tmo0}), 32'b100);
    chk("bad_ts_val",    tsv0, 32'h56E0_0000);
    repeat (3) @(negedge clk);
    chk("no_queue",      32'({done0, busy0}), 32'b10);

    // Re-probe from DONE with the correct timestamp
    sts0 = TS_DEF;
    start0 = 1'b1; @(negedge clk); start0 = 1'b0;
    wait_done(0, "reprobe_done", 10);
    chk("reprobe_status", 32'({idok0, tsok0, tmo0}), 32'b110);
    chk("reprobe_ts_val", tsv0, TS_DEF);

    // Five stall cycles per read on u1: read/address hold, drop after acceptance
    wait_n1 = 5;
    start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    stalls = 0;
    for (int k = 0; k < 40 && done1 !== 1'b1; k++) begin
      held_ad    = addr1;
      was_accept = read1 && !wait1;
      if (read1 && wait1) stalls++;
      if (read1 && wait1) begin
        @(negedge clk);
        chk("stall_hold", 32'({read1, addr1}), 32'({1'b1, held_ad}));
      end else begin
        @(negedge clk);
        if (was_accept) chk("drop_after_accept", 32'(read1), 32'd0);
      end
    end
    chk("stall_count",   32'(stalls), 32'd10);
    chk("stall_done",    32'(done1), 32'd1);
    chk("stall_status",  32'({idok1, tsok1, tmo1}), 32'b110);
    chk("stall_id_val",  idv1, ID1);
    chk("stall_ts_val",  tsv1, TS1);

    // Waitrequest stuck high: timeout after 8 stalled cycles
    wait_n1 = 1000;
    start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    rd_cycles = 0;
    for (int k = 0; k < 30 && done1 !== 1'b1; k++) begin
      if (read1) rd_cycles++;
      @(negedge clk);
    end
    chk("tmo_read_cycles", 32'(rd_cycles), 32'd8);
    chk("tmo_status", 32'({done1, tmo1, idok1, tsok1, busy1, read1}), 32'b110000);

    // Reset asserted during LAT_TS, then a fresh auto-started probe
    wait_n1 = 0;
    start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    chk("tmo_cleared", 32'({tmo1, done1}), 32'd0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (busy1 && !read1 && addr1) found = 1'b1;
      else @(negedge clk);
    end
    chk("reach_lat_ts", 32'(found), 32'd1);
    chk("lat_ts_id_ok", 32'(idok1), 32'd1);
    #1 rst1_n = 1'b0;
    #1;
    chk("async_rst_flags", 32'({read1, addr1, busy1, done1, idok1, tsok1, tmo1}), 32'd0);
    chk("async_rst_vals",  idv1 | tsv1, 32'd0);
    @(negedge clk);
    rst1_n = 1'b1;
    @(negedge clk);
    chk("post_rst_launch", 32'({busy1, read1, addr1}), 32'b110);
    chk("no_late_capture", tsv1, 32'd0);
    wait_done(1, "post_rst_done", 20);
    chk("post_rst_status", 32'({idok1, tsok1, tmo1}), 32'b110);
    chk("post_rst_ts_val", tsv1, TS1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
